ham_fix: RTL and testbench

Single-error-correcting decoder for the Hamming(15,11) code. It takes a 15-bit received codeword and recomputes its 4-bit syndrome. If the syndrome is nonzero, it inverts the bit it addresses, then registers the corrected 15-bit codeword. It sits on the receive side of a link or memory path, after the raw codeword arrives and before data extraction.

---
 rtl/ham_fix_pkg.sv | 18 +
 rtl/ham_fix_if.sv | 12 +
 rtl/ham_fix_syndrome.sv | 15 +
 rtl/ham_fix.sv | 37 +++
 tb/tb_ham_fix.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/ham_fix_pkg.sv
// Shared geometry, types and syndrome position masks for the Hamming(15,11) decoder.
// Bit n of a ham_word_t is codeword position n; mask bit set means that position feeds the syndrome bit.
package ham_pkg;

    localparam int HAM_N = 15;
    localparam int HAM_K = 11;
    localparam int HAM_R = 4;

    typedef logic [15:1] ham_word_t;
    typedef logic [3:0]  ham_syn_t;

    // Position p contributes to syndrome bit i exactly when bit i of p is set
    localparam ham_word_t SYN_MASK0 = 15'h5555;
    localparam ham_word_t SYN_MASK1 = 15'h6666;
    localparam ham_word_t SYN_MASK2 = 15'h7878;
    localparam ham_word_t SYN_MASK3 = 15'h7F80;

endpackage

// File: rtl/ham_fix_if.sv
// Received/corrected codeword bundle; master is the link side, slave is the decoder.
// No handshake: a new codeword is presented every cycle.
interface ham_fix_if;
    import ham_pkg::*;

    ham_word_t ham;
    ham_word_t fixed;

    modport master (output ham, input fixed);
    modport slave  (input ham, output fixed);

endinterface

// File: rtl/ham_fix_syndrome.sv
// Combinational syndrome of a received Hamming(15,11) word; zero latency, no backpressure.
// A nonzero result is the position of the single flipped bit.
module ham_syndrome
    import ham_pkg::*;
(
    input  ham_word_t i_word,
    output ham_syn_t  o_syn
);

    assign o_syn[0] = ^(i_word & SYN_MASK0);
    assign o_syn[1] = ^(i_word & SYN_MASK1);
    assign o_syn[2] = ^(i_word & SYN_MASK2);
    assign o_syn[3] = ^(i_word & SYN_MASK3);

endmodule

// File: rtl/ham_fix.sv
// Hamming(15,11) single-error corrector: inverts the position addressed by the syndrome.
// One-cycle latency, one word per cycle, never stalls; double errors are miscorrected by design.
module ham_fix
    import ham_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    ham_fix_if.slave   bus
);

    ham_syn_t    w_syn;
    logic [15:0] w_onehot;
    ham_word_t   w_flip;
    ham_word_t   w_corr;
    ham_word_t   r_fixed;

    ham_syndrome u_syndrome (
        .i_word (bus.ham),
        .o_syn  (w_syn)
    );

    // Bit 0 of the decode is the "no error" slot and is dropped by the slice
    assign w_onehot = 16'd1 << w_syn;
    assign w_flip   = (w_syn == '0) ? '0 : w_onehot[15:1];
    assign w_corr   = bus.ham ^ w_flip;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fixed <= '0;
        end else begin
            r_fixed <= w_corr;
        end
    end

    assign bus.fixed = r_fixed;

endmodule

// File: tb/tb_ham_fix.sv
// Scoreboarded bench for ham_fix: directed vectors, exhaustive single errors, random double errors.
module tb_ham_fix;
    import ham_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ham_fix_if bus ();

    ham_fix u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    ham_word_t exp_q[$];
    string     name_q[$];
    int        checks = 0;
    int        errors = 0;

    // Places data bits in the non-power-of-two positions, then picks parity so all positions XOR to zero
    function automatic ham_word_t encode(input logic [10:0] d);
        ham_word_t w = '0;
        int        s = 0;
        int        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p] = d[j];
                if (d[j]) s = s ^ p;
                j++;
            end
        end
        for (int i = 0; i < 4; i++) w[1 << i] = s[i];
        return w;
    endfunction

    // The XOR of the positions of all set bits is the syndrome
    function automatic ham_word_t ref_fix(input ham_word_t w_in);
        ham_word_t w = w_in;
        int        s = 0;
        for (int p = 1; p <= 15; p++) if (w[p]) s = s ^ p;
        if (s != 0) w[s] = ~w[s];
        return w;
    endfunction

    task automatic check(input string name, input ham_word_t act, input ham_word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input string name, input ham_word_t w, input ham_word_t e);
        @(negedge clock);
        bus.ham = w;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: each rising edge out of reset consumes one queued expectation
    always @(posedge clock) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            check(name_q.pop_front(), bus.fixed, exp_q.pop_front());
        end
    end

    initial begin
        ham_word_t w;
        int        d;
        int        p1;
        int        p2;

        bus.ham = 15'h7FFF;
        #2 reset = 1'b1;
        #1 check("rst_async", bus.fixed, 15'h0000);
        repeat (3) begin
            @(posedge clock);
            #1 check("rst_hold", bus.fixed, 15'h0000);
        end

        @(negedge clock);
        reset   = 1'b0;
        bus.ham = 15'h7FFF;
        exp_q.push_back(15'h7FFF);
        name_q.push_back("rst_first");

        drive("clean",     15'h552D, 15'h552D);
        drive("data_p7",   15'h556D, 15'h552D);
        drive("data_p15",  15'h3FFF, 15'h7FFF);
        drive("par_p1",    15'h552C, 15'h552D);
        drive("par_p8",    15'h55AD, 15'h552D);
        drive("double_12", 15'h552E, 15'h552A);

        // Inputs that move between edges must not disturb the registered word
        drive("hold_pre",  15'h552D, 15'h552D);
        @(posedge clock);
        #2 bus.ham = 15'h0F0F;
        #2 check("hold_mid", bus.fixed, 15'h552D);

        for (int dv = 0; dv < 2048; dv++) begin
            for (int e = 0; e < 16; e++) begin
                w = encode(11'(dv));
                if (e != 0) w[e] = ~w[e];
                drive("exhaustive", w, encode(11'(dv)));
            end
        end

        for (int n = 0; n < 300; n++) begin
            d  = $urandom_range(0, 2047);
            p1 = $urandom_range(1, 15);
            p2 = $urandom_range(1, 14);
            if (p2 >= p1) p2++;
            w = encode(11'(d));
            w[p1] = ~w[p1];
            w[p2] = ~w[p2];
            drive("double_rand", w, ref_fix(w));
        end

        for (int n = 0; n < 300; n++) begin
            w = ham_word_t'($urandom);
            drive("any_rand", w, ref_fix(w));
        end

        drive("mid_a", 15'h556D, 15'h552D);
        @(posedge clock);
        #3 reset = 1'b1;
        #1 check("rst_mid", bus.fixed, 15'h0000);
        @(posedge clock);
        #1 check("rst_mid_hold", bus.fixed, 15'h0000);
        @(negedge clock);
        reset = 1'b0;
        drive("post_rst", 15'h55AD, 15'h552D);

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
